conf_int_add__apx_err_monitor: RTL and testbench

- Stage directly downstream of the duplicated-PE approximate integer adder wrapper.
- Consumes both the 25-bit accurate result and the zero-padded 25-bit approximate result each valid cycle, and measures absolute error over fixed sample windows.
- Drives the wrapper's acc__sel through a two-state hysteresis FSM, and forwards a registered selected result to the next datapath stage.

---
 rtl/conf_int_add__apx_err_monitor.sv | 116 +++++++++++
 tb/tb_conf_int_add__apx_err_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_int_add__apx_err_monitor.sv
// Approximate-adder error monitor: windowed |acc - apx| sums drive a hysteresis
// select FSM.  States: APX | approximate result selected;  ACC | accurate result selected (hold >= 0).
module conf_int_add__apx_err_monitor #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int WIN_LOG2           = 4,
  parameter int ERR_SUM_W          = 32,
  parameter int ERR_THRESH         = 1024,
  parameter int HOLD_WINDOWS       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [24:0]          d__acc,
  input  logic [24:0]          d__apx,
  input  logic                 force_acc,
  output logic                 acc__sel,
  output logic [24:0]          d_out,
  output logic                 out_valid,
  output logic                 win_done,
  output logic [ERR_SUM_W-1:0] err_win_sum
);

  localparam int APX_ZB = 24 - DATA_PATH_BITWIDTH;
  localparam logic [24:0] APX_MASK = ~((25'd1 << APX_ZB) - 25'd1);
  localparam int SW = ((ERR_SUM_W > 25) ? ERR_SUM_W : 25) + 1;
  localparam logic [SW-1:0] SAT_MAX = SW'({ERR_SUM_W{1'b1}});
  localparam int HW = (HOLD_WINDOWS < 1) ? 1 : $clog2(HOLD_WINDOWS + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_WINDOWS);
  localparam logic [63:0] THR_HI = 64'(ERR_THRESH);
  localparam logic [63:0] THR_LO = THR_HI >> 1;

  typedef enum logic {APX = 1'b0, ACC = 1'b1} state_t;

  state_t                 state, state_next;
  logic [HW-1:0]          hold, hold_next, hold_dec;
  logic [WIN_LOG2-1:0]    cnt;
  logic [ERR_SUM_W-1:0]   acc_sum, sat_sum;
  logic [24:0]            apx_clean, err;
  logic [SW-1:0]          sum_wide;
  logic                   win_close, force_acc_q, above, below_lo;

  // Low approximate bits are structurally zero; masking keeps stray bits out of the error.
  assign apx_clean = d__apx & APX_MASK;
  assign err       = (d__acc >= apx_clean) ? (d__acc - apx_clean) : (apx_clean - d__acc);
  assign sum_wide  = SW'(acc_sum) + SW'(err);
  assign sat_sum   = (sum_wide > SAT_MAX) ? {ERR_SUM_W{1'b1}} : sum_wide[ERR_SUM_W-1:0];
  assign win_close = in_valid && (cnt == {WIN_LOG2{1'b1}});
  assign above     = 64'(sat_sum) > THR_HI;
  assign below_lo  = 64'(sat_sum) <= THR_LO;
  assign hold_dec  = (hold == '0) ? '0 : hold - HW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= APX;
      hold  <= '0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold;
    if (win_close) begin
      case (state)
        APX: begin
          if (above) begin
            state_next = ACC;
            hold_next  = HOLD_INIT;
          end
        end
        ACC: begin
          if (above) begin
            hold_next = HOLD_INIT;
          end else begin
            hold_next = hold_dec;
            if ((hold_dec == '0) && below_lo) state_next = APX;
          end
        end
        default: state_next = APX;
      endcase
    end
  end

  always_comb begin
    acc__sel = (state == ACC) | force_acc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      force_acc_q <= 1'b0;
      cnt         <= '0;
      acc_sum     <= '0;
      d_out       <= '0;
      out_valid   <= 1'b0;
      win_done    <= 1'b0;
      err_win_sum <= '0;
    end else begin
      force_acc_q <= force_acc;
      out_valid   <= in_valid;
      win_done    <= win_close;
      if (in_valid) begin
        d_out <= acc__sel ? d__acc : d__apx;
        cnt   <= cnt + WIN_LOG2'(1);
        if (win_close) begin
          err_win_sum <= sat_sum;
          acc_sum     <= '0;
        end else begin
          acc_sum <= sat_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_conf_int_add__apx_err_monitor.sv
// Bench for the error monitor: two instances (wide and 8-bit accumulator) against a window-level model.
module tb_conf_int_add__apx_err_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        force_acc = 1'b0;
  logic [24:0] d_acc = '0;
  logic [24:0] d_apx = '0;

  logic        sel0, ov0, wd0, sel1, ov1, wd1;
  logic [24:0] dout0, dout1;
  logic [31:0] ews0;
  logic [7:0]  ews1;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  conf_int_add__apx_err_monitor #(.DATA_PATH_BITWIDTH(16), .WIN_LOG2(2), .ERR_SUM_W(32),
                                  .ERR_THRESH(100), .HOLD_WINDOWS(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d__acc(d_acc), .d__apx(d_apx),
    .force_acc(force_acc), .acc__sel(sel0), .d_out(dout0), .out_valid(ov0),
    .win_done(wd0), .err_win_sum(ews0));

  conf_int_add__apx_err_monitor #(.DATA_PATH_BITWIDTH(16), .WIN_LOG2(2), .ERR_SUM_W(8),
                                  .ERR_THRESH(100), .HOLD_WINDOWS(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d__acc(d_acc), .d__apx(d_apx),
    .force_acc(force_acc), .acc__sel(sel1), .d_out(dout1), .out_valid(ov1),
    .win_done(wd1), .err_win_sum(ews1));

  // Reference model: each window is a list of errors, summed and clamped when it fills.
  localparam longint MAXV [2] = '{64'hFFFF_FFFF, 64'hFF};
  bit          m_acc_st [2];
  int          m_hold   [2];
  longint      m_win    [2][$];
  logic [24:0] m_dout   [2];
  bit          m_ov     [2];
  bit          m_wd     [2];
  longint      m_ews    [2];
  bit          m_fq;

  task automatic model_update();
    longint e, s;
    bit sel_old;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_acc_st[i] = 0; m_hold[i] = 0; m_win[i].delete(); m_dout[i] = '0;
        m_ov[i] = 0; m_wd[i] = 0; m_ews[i] = 0;
      end
      m_fq = 0;
      return;
    end
    e = (d_acc >= d_apx) ? longint'(d_acc) - longint'(d_apx) : longint'(d_apx) - longint'(d_acc);
    for (int i = 0; i < 2; i++) begin
      sel_old = m_acc_st[i] | m_fq;
      m_ov[i] = in_valid;
      m_wd[i] = 0;
      if (in_valid) begin
        m_dout[i] = sel_old ? d_acc : d_apx;
        m_win[i].push_back(e);
        if (m_win[i].size() == 4) begin
          s = 0;
          foreach (m_win[i][k]) s += m_win[i][k];
          if (s > MAXV[i]) s = MAXV[i];
          m_ews[i] = s;
          m_wd[i]  = 1;
          m_win[i].delete();
          if (s > 100) begin
            m_acc_st[i] = 1;
            m_hold[i]   = 2;
          end else if (m_acc_st[i]) begin
            if (m_hold[i] > 0) m_hold[i]--;
            if (m_hold[i] == 0 && s <= 50) m_acc_st[i] = 0;
          end
        end
      end
    end
    m_fq = force_acc;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("sel0", sel0, m_acc_st[0] | m_fq);
    check("ov0", ov0, m_ov[0]);
    check("dout0", dout0, m_dout[0]);
    check("wd0", wd0, m_wd[0]);
    check("ews0", ews0, m_ews[0]);
    check("sel1", sel1, m_acc_st[1] | m_fq);
    check("ov1", ov1, m_ov[1]);
    check("dout1", dout1, m_dout[1]);
    check("wd1", wd1, m_wd[1]);
    check("ews1", ews1, m_ews[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drive_sample(input int e);
    logic [15:0] r;
    r = 16'($urandom);
    d_apx = {1'b0, r, 8'h00};
    if (($urandom % 2 == 1 || d_apx + 25'(e) > 25'h1FF_FFFF) && d_apx >= 25'(e))
      d_acc = d_apx - 25'(e);
    else
      d_acc = d_apx + 25'(e);
    in_valid = 1'b1;
  endtask

  task automatic sample(input int e);
    drive_sample(e);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      d_acc = 25'($urandom);
      d_apx = 25'($urandom);
      cyc();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_valid  = 1'($urandom);
      force_acc = 1'($urandom);
      d_acc = 25'($urandom);
      d_apx = 25'($urandom);
      cyc();
    end
    in_valid  = 1'b0;
    force_acc = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    logic [24:0] apx_save;
    int r, e;

    // Reset with random inputs, then first sample
    do_reset(3);
    check("rst_sel", sel0, 1'b0);
    check("rst_ov", ov0, 1'b0);
    check("rst_wd", wd0, 1'b0);
    check("rst_ews", ews0, 32'd0);
    drive_sample(40);
    apx_save = d_apx;
    cyc();
    in_valid = 1'b0;
    check("first_ov", ov0, 1'b1);
    check("first_dout", dout0, apx_save);

    // err=128 window enters ACC
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      drive_sample(128);
      apx_save = d_apx;
      cyc();
      in_valid = 1'b0;
      if (k < 3) begin
        check("a_wd_low", wd0, 1'b0);
        idle(1);
      end
    end
    check("a_wd", wd0, 1'b1);
    check("a_sum", ews0, 32'd512);
    check("a_sel", sel0, 1'b1);
    check("a_close_dout", dout0, apx_save);
    check("a_sat8", ews1, 8'd255);
    idle(1);
    check("a_wd_pulse", wd0, 1'b0);

    // Low-error windows while in ACC: hold 2 -> 1 (stay), 1 -> 0 (leave)
    for (int k = 0; k < 4; k++) sample(5);
    check("c_sum", ews0, 32'd20);
    check("c_sel_hold", sel0, 1'b1);
    for (int k = 0; k < 4; k++) sample(5);
    check("c_sel_drop", sel0, 1'b0);

    // Sum exactly at threshold does not trigger
    do_reset(1);
    for (int k = 0; k < 4; k++) sample(25);
    check("b_sum", ews0, 32'd100);
    check("b_sel", sel0, 1'b0);

    // 8-bit accumulator saturates
    do_reset(1);
    sample(200); sample(200); sample(0); sample(0);
    check("d_sat8", ews1, 8'd255);
    check("d_sum32", ews0, 32'd400);

    // force_acc pulse mid-window
    do_reset(1);
    sample(10); sample(10);
    force_acc = 1'b1;
    idle(1);
    check("e_force_on", sel0, 1'b1);
    force_acc = 1'b0;
    idle(1);
    check("e_force_off", sel0, 1'b0);
    sample(10); sample(10);
    check("e_sum", ews0, 32'd40);

    // Reset mid-window discards the partial window
    do_reset(1);
    sample(30); sample(30);
    do_reset(1);
    check("f_wd", wd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      sample(7);
      check("f_wd_low", wd0, 1'b0);
    end
    sample(7);
    check("f_wd_close", wd0, 1'b1);
    check("f_sum", ews0, 32'd28);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom % 150) != 0;
      force_acc = ($urandom % 16) == 0;
      r = int'($urandom % 8);
      if (r < 6) e = int'($urandom_range(0, 50));
      else if (r == 6) e = int'($urandom_range(100, 400));
      else e = 0;
      if ($urandom % 3 != 0) begin
        drive_sample(e);
      end else begin
        in_valid = 1'b0;
        d_acc = 25'($urandom);
        d_apx = 25'($urandom);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
